sv32_ptw: RTL

- Sv32 hardware page-table walker.
- Consumes ITLB misses (VPN + ASID), fetches and decodes pte_t entries from memory, and returns either a leaf PTE (4KB or 4MB) or a fault to the ITLB refill path.
- Sits between the ITLB miss logic and the L1-side memory read port; one walk in flight at a time.

---
 rtl/sv32_ptw_pkg.sv | 16 +
 rtl/sv32_pte_check.sv | 25 ++
 rtl/sv32_ptw.sv | 101 ++++++++++
 3 files changed

// File: rtl/sv32_ptw_pkg.sv
// sv32_ptw_pkg: shared Sv32 walker types, widths and constants
package sv32_ptw_pkg;
  localparam int VPN_W = 20;
  localparam int PPN_W = 22;
  localparam int ASID_W = 9;
  localparam int PA_W = 34;
  localparam int PTE_ADDR_BYTES = 4;
  localparam int PTE_OFS_W = $clog2(PTE_ADDR_BYTES);
  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP} ptw_state_t;
  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0] ppn0;
    logic [1:0] rsw;
    logic d, a, g, u, x, w, r, v;
  } pte_t;
endpackage

// File: rtl/sv32_pte_check.sv
// sv32_pte_check: classifies one returned PTE at the current walk level
// level=1 first level, level=0 second; ppn0/a/x/w/r/v are pte_t fields
// leaf: usable translation, next: descend one level, page_fault: reject
module sv32_pte_check #(parameter bit CHECK_A_BIT = 1'b1) (
  input logic level,
  input logic [9:0] ppn0,
  input logic a,
  input logic x,
  input logic w,
  input logic r,
  input logic v,
  output logic leaf,
  output logic next,
  output logic page_fault
);
  logic bad, is_leaf;
  always_comb begin
    bad = !v || (!r && w);
    is_leaf = r || x;
    // a first-level leaf must be 4MB aligned; a second-level pointer has nowhere to go
    page_fault = bad || (is_leaf ? (level && ppn0 != '0) || (CHECK_A_BIT && !a) : !level);
    leaf = !page_fault && is_leaf;
    next = !page_fault && !is_leaf;
  end
endmodule

// File: rtl/sv32_ptw.sv
// sv32_ptw: Sv32 page-table walker serving ITLB misses, one walk at a time
// req_*: miss request (VPN, ASID) sampled with satp_PPN when req_ready
// mem_*: single outstanding PTE read, word-aligned 34-bit PA
// resp_*: leaf PTE or fault, held until resp_ready
module sv32_ptw
  import sv32_ptw_pkg::*;
#(parameter bit CHECK_A_BIT = 1'b1) (
  input logic CLK,
  input logic RST,
  input logic [PPN_W-1:0] satp_PPN,
  input logic req_valid,
  output logic req_ready,
  input logic [VPN_W-1:0] req_VPN,
  input logic [ASID_W-1:0] req_ASID,
  output logic mem_req_valid,
  input logic mem_req_ready,
  output logic [PA_W-1:0] mem_req_PA,
  input logic mem_resp_valid,
  input logic mem_resp_error,
  input logic [31:0] mem_resp_PTE,
  output logic resp_valid,
  input logic resp_ready,
  output logic [VPN_W-1:0] resp_VPN,
  output logic [ASID_W-1:0] resp_ASID,
  output logic [31:0] resp_PTE,
  output logic resp_superpage,
  output logic resp_page_fault,
  output logic resp_access_fault
);
  ptw_state_t state;
  pte_t pte;
  logic level, leaf, next, pf, ok;
  assign pte = mem_resp_PTE;
  assign level = state == L1_WAIT;
  assign ok = !mem_resp_error;
  sv32_pte_check #(.CHECK_A_BIT(CHECK_A_BIT)) u_check (
    .level(level),
    .ppn0(pte.ppn0),
    .a(pte.a),
    .x(pte.x),
    .w(pte.w),
    .r(pte.r),
    .v(pte.v),
    .leaf(leaf),
    .next(next),
    .page_fault(pf)
  );
  // resp_VPN/resp_ASID double as the latched request; satp only lives on in mem_req_PA
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      req_ready <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_PA <= '0;
      resp_valid <= 1'b0;
      resp_VPN <= '0;
      resp_ASID <= '0;
      resp_PTE <= '0;
      resp_superpage <= 1'b0;
      resp_page_fault <= 1'b0;
      resp_access_fault <= 1'b0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          state <= L1_REQ;
          req_ready <= 1'b0;
          resp_VPN <= req_VPN;
          resp_ASID <= req_ASID;
          mem_req_valid <= 1'b1;
          mem_req_PA <= {satp_PPN, req_VPN[19:10], {PTE_OFS_W{1'b0}}};
        end
        L1_REQ, L0_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state <= state == L1_REQ ? L1_WAIT : L0_WAIT;
        end
        L1_WAIT, L0_WAIT: if (mem_resp_valid) begin
          if (ok && next) begin
            state <= L0_REQ;
            mem_req_valid <= 1'b1;
            mem_req_PA <= {pte.ppn1, pte.ppn0, resp_VPN[9:0], {PTE_OFS_W{1'b0}}};
          end else begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_access_fault <= mem_resp_error;
            resp_page_fault <= ok && pf;
            resp_PTE <= ok && leaf ? pte : '0;
            resp_superpage <= ok && leaf && level;
          end
        end
        RESP: if (resp_ready) begin
          state <= IDLE;
          req_ready <= 1'b1;
          resp_valid <= 1'b0;
          resp_PTE <= '0;
          resp_superpage <= 1'b0;
          resp_page_fault <= 1'b0;
          resp_access_fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule
